// File: rtl/coax_pulse_shaper.sv
`timescale 1ns/1ps
// rtl/coax_pulse_shaper.sv - per-channel coax pulse shaper with dead time and fire counters (option: COAX_VETO_COUNT_EN)
module coax_pulse_shaper #(
    parameter int NCH   = 16,
    parameter int NHIST = 4,
    parameter int CNTW  = 32
) (
    input  logic                  clk_adc,
    input  logic                  nrst,
    input  logic [NCH-1:0]        coax_in,
    input  logic [7:0]            firingticks,
    input  logic [7:0]            deadticks,
    input  logic                  resethist,
    output logic [NCH-1:0]        coax_out,
    output logic [NHIST*CNTW-1:0] histos,
    output logic [NCH-1:0]        busy
`ifdef COAX_VETO_COUNT_EN
    ,
    output logic [NHIST*16-1:0]   veto_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    logic [NCH-1:0]             sync1;
    logic [NCH-1:0]             sync2;
    logic [NCH-1:0]             sync_prev;
    logic [NCH-1:0]             edge_q;
    state_t                     state_q  [NCH];
    logic [7:0]                 cnt_q    [NCH];
    logic [7:0]                 dead_lat [NCH];
    logic [7:0]                 fire_len;
    logic [NHIST-1:0][CNTW-1:0] hist_q;

    // A zero pulse length still produces a one-cycle pulse.
    assign fire_len = (firingticks == 8'd0) ? 8'd1 : firingticks;

    // Two-flop synchronizer, a delayed copy, and a registered rising-edge strobe.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
            edge_q    <= '0;
        end else begin
            sync1     <= coax_in;
            sync2     <= sync1;
            sync_prev <= sync2;
            edge_q    <= sync2 & ~sync_prev;
        end
    end

    // Per-channel IDLE/FIRE/DEAD machine; coax_out and busy are registered with the state.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= S_IDLE;
                cnt_q[i]    <= 8'd0;
                dead_lat[i] <= 8'd0;
            end
            coax_out <= '0;
            busy     <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (state_q[i])
                    S_IDLE: begin
                        if (edge_q[i]) begin
                            state_q[i]  <= S_FIRE;
                            cnt_q[i]    <= fire_len;
                            dead_lat[i] <= deadticks;
                            coax_out[i] <= 1'b1;
                            busy[i]     <= 1'b1;
                        end
                    end
                    S_FIRE: begin
                        if (cnt_q[i] == 8'd1) begin
                            coax_out[i] <= 1'b0;
                            if (dead_lat[i] != 8'd0) begin
                                state_q[i] <= S_DEAD;
                                cnt_q[i]   <= dead_lat[i];
                            end else begin
                                state_q[i] <= S_IDLE;
                                cnt_q[i]   <= 8'd0;
                                busy[i]    <= 1'b0;
                            end
                        end else begin
                            cnt_q[i] <= cnt_q[i] - 8'd1;
                        end
                    end
                    S_DEAD: begin
                        if (cnt_q[i] == 8'd1) begin
                            state_q[i] <= S_IDLE;
                            cnt_q[i]   <= 8'd0;
                            busy[i]    <= 1'b0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] - 8'd1;
                        end
                    end
                    default: begin
                        state_q[i]  <= S_IDLE;
                        cnt_q[i]    <= 8'd0;
                        coax_out[i] <= 1'b0;
                        busy[i]     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating accepted-fire counters; a clear beats a coincident fire.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            hist_q <= '0;
        end else begin
            for (int i = 0; i < NHIST; i++) begin
                if (resethist) begin
                    hist_q[i] <= '0;
                end else if (edge_q[i] && !busy[i] && (hist_q[i] != {CNTW{1'b1}})) begin
                    hist_q[i] <= hist_q[i] + CNTW'(1);
                end
            end
        end
    end

    assign histos = hist_q;

`ifdef COAX_VETO_COUNT_EN
    logic [NHIST-1:0][15:0] veto_q;

    // Saturating count of edges that arrive while the channel is still busy.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            veto_q <= '0;
        end else begin
            for (int i = 0; i < NHIST; i++) begin
                if (resethist) begin
                    veto_q[i] <= '0;
                end else if (edge_q[i] && busy[i] && (veto_q[i] != 16'hFFFF)) begin
                    veto_q[i] <= veto_q[i] + 16'd1;
                end
            end
        end
    end

    assign veto_cnt = veto_q;
`endif

endmodule

// File: tb/tb_coax_pulse_shaper.sv
`timescale 1ns/1ps
// tb/tb_coax_pulse_shaper.sv - directed and randomized self-checking bench for coax_pulse_shaper
module tb_coax_pulse_shaper;
    localparam int NCH   = 16;
    localparam int NHIST = 4;
    localparam int CNTW  = 4;
    localparam int HMAX  = (1 << CNTW) - 1;

    logic                  clk_adc     = 1'b0;
    logic                  nrst        = 1'b0;
    logic [NCH-1:0]        coax_in     = '0;
    logic [7:0]            firingticks = '0;
    logic [7:0]            deadticks   = '0;
    logic                  resethist   = 1'b0;
    logic [NCH-1:0]        coax_out;
    logic [NHIST*CNTW-1:0] histos;
    logic [NCH-1:0]        busy;
`ifdef COAX_VETO_COUNT_EN
    logic [NHIST*16-1:0]   veto_cnt;
`endif

    coax_pulse_shaper #(.NCH(NCH), .NHIST(NHIST), .CNTW(CNTW)) dut (
        .clk_adc     (clk_adc),
        .nrst        (nrst),
        .coax_in     (coax_in),
        .firingticks (firingticks),
        .deadticks   (deadticks),
        .resethist   (resethist),
        .coax_out    (coax_out),
        .histos      (histos),
`ifdef COAX_VETO_COUNT_EN
        .veto_cnt    (veto_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk_adc = ~clk_adc;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: time-stamped edges and the start/length of the latest accepted pulse.
    int cyc = 0;
    bit prev_in [NCH];
    int edge_ts [NCH][$];
    int m_start [NCH];
    int m_f     [NCH];
    int m_d     [NCH];
    int m_hist  [NHIST];
    int m_veto  [NHIST];

    int hi_cnt     [NCH];
    int busy_cnt   [NCH];
    int rises      [NCH];
    int first_rise [NCH];
    logic [NCH-1:0] prev_out = '0;
    int k;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            prev_in[ch] = 1'b0;
            edge_ts[ch].delete();
            m_start[ch] = -1;
            m_f[ch] = 0;
            m_d[ch] = 0;
        end
        for (int h = 0; h < NHIST; h++) begin
            m_hist[h] = 0;
            m_veto[h] = 0;
        end
        prev_out = '0;
    endtask

    task automatic clr_stats();
        for (int ch = 0; ch < NCH; ch++) begin
            hi_cnt[ch] = 0;
            busy_cnt[ch] = 0;
            rises[ch] = 0;
            first_rise[ch] = -1;
        end
    endtask

    // An input edge sampled at edge k starts a pulse at edge k+3 unless the
    // previous pulse plus dead time has not fully elapsed by edge k+2.
    task automatic model_posedge();
        for (int ch = 0; ch < NCH; ch++) begin
            if (edge_ts[ch].size() > 0 && edge_ts[ch][0] == cyc - 3) begin
                void'(edge_ts[ch].pop_front());
                if (m_start[ch] < 0 || cyc > m_start[ch] + m_f[ch] + m_d[ch]) begin
                    m_start[ch] = cyc;
                    m_f[ch] = (firingticks == 8'd0) ? 1 : int'(firingticks);
                    m_d[ch] = int'(deadticks);
                    if (ch < NHIST && m_hist[ch] < HMAX) m_hist[ch]++;
                end else if (ch < NHIST && m_veto[ch] < 65535) begin
                    m_veto[ch]++;
                end
            end
            if (coax_in[ch] && !prev_in[ch]) edge_ts[ch].push_back(cyc);
            prev_in[ch] = coax_in[ch];
        end
        if (resethist) begin
            for (int h = 0; h < NHIST; h++) begin
                m_hist[h] = 0;
                m_veto[h] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0]        ec;
        logic [NCH-1:0]        eb;
        logic [NHIST*CNTW-1:0] eh;
        logic [NHIST*16-1:0]   ev;
        ec = '0;
        eb = '0;
        eh = '0;
        ev = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (m_start[ch] >= 0) begin
                ec[ch] = (cyc < m_start[ch] + m_f[ch]);
                eb[ch] = (cyc < m_start[ch] + m_f[ch] + m_d[ch]);
            end
        end
        for (int h = 0; h < NHIST; h++) begin
            eh[h*CNTW +: CNTW] = CNTW'(m_hist[h]);
            ev[h*16 +: 16] = 16'(m_veto[h]);
        end
        check("coax_out", 64'(coax_out), 64'(ec));
        check("busy", 64'(busy), 64'(eb));
        check("histos", 64'(histos), 64'(eh));
`ifdef COAX_VETO_COUNT_EN
        check("veto_cnt", 64'(veto_cnt), 64'(ev));
`endif
        for (int ch = 0; ch < NCH; ch++) begin
            if (coax_out[ch]) hi_cnt[ch]++;
            if (busy[ch]) busy_cnt[ch]++;
            if (coax_out[ch] && !prev_out[ch]) begin
                rises[ch]++;
                if (first_rise[ch] < 0) first_rise[ch] = cyc;
            end
        end
        prev_out = coax_out;
    endtask

    task automatic tick();
        @(posedge clk_adc);
        if (nrst) begin
            cyc++;
            model_posedge();
        end
        @(negedge clk_adc);
        if (nrst) check_all();
    endtask

    task automatic do_reset(input int hold);
        nrst = 1'b0;
        #1;
        model_reset();
        check("rst_coax_out", 64'(coax_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_histos", 64'(histos), 64'd0);
        repeat (hold) tick();
        nrst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        clr_stats();
        @(negedge clk_adc);
        do_reset(3);

        // Single 4-cycle pulse with 10 cycles dead time on channel 0.
        firingticks = 8'd4;
        deadticks = 8'd10;
        clr_stats();
        coax_in[0] = 1'b1;
        tick();
        k = cyc;
        coax_in[0] = 1'b0;
        repeat (20) tick();
        check("ch0_latency", 64'(first_rise[0]), 64'(k + 3));
        check("ch0_width", 64'(hi_cnt[0]), 64'd4);
        check("ch0_busy", 64'(busy_cnt[0]), 64'd14);
        check("ch0_hist", 64'(histos[0 +: CNTW]), 64'd1);

        // Zero lengths: five one-cycle pulses on channel 1.
        firingticks = 8'd0;
        deadticks = 8'd0;
        clr_stats();
        repeat (5) begin
            coax_in[1] = 1'b1;
            repeat (4) tick();
            coax_in[1] = 1'b0;
            repeat (4) tick();
        end
        repeat (4) tick();
        check("ch1_rises", 64'(rises[1]), 64'd5);
        check("ch1_width", 64'(hi_cnt[1]), 64'd5);
        check("ch1_hist", 64'(histos[CNTW +: CNTW]), 64'd5);

        // Second edge on channel 2 lands in dead time and is dropped.
        firingticks = 8'd2;
        deadticks = 8'd20;
        clr_stats();
        coax_in[2] = 1'b1;
        tick();
        coax_in[2] = 1'b0;
        repeat (9) tick();
        coax_in[2] = 1'b1;
        tick();
        coax_in[2] = 1'b0;
        repeat (30) tick();
        check("ch2_rises", 64'(rises[2]), 64'd1);
        check("ch2_hist", 64'(histos[2*CNTW +: CNTW]), 64'd1);
`ifdef COAX_VETO_COUNT_EN
        check("ch2_veto", 64'(veto_cnt[2*16 +: 16]), 64'd1);
`endif

        // Pulse length change mid-pulse on channel 3 only affects the next pulse.
        firingticks = 8'd3;
        deadticks = 8'd0;
        clr_stats();
        coax_in[3] = 1'b1;
        tick();
        coax_in[3] = 1'b0;
        repeat (4) tick();
        firingticks = 8'd8;
        repeat (6) tick();
        check("ch3_first_width", 64'(hi_cnt[3]), 64'd3);
        clr_stats();
        coax_in[3] = 1'b1;
        tick();
        coax_in[3] = 1'b0;
        repeat (14) tick();
        check("ch3_second_width", 64'(hi_cnt[3]), 64'd8);

        // Counter saturation at 15, then a clear coincident with a fire.
        resethist = 1'b1;
        tick();
        resethist = 1'b0;
        firingticks = 8'd1;
        deadticks = 8'd0;
        repeat (15) begin
            coax_in[0] = 1'b1;
            repeat (2) tick();
            coax_in[0] = 1'b0;
            repeat (2) tick();
        end
        repeat (4) tick();
        check("ch0_hist_full", 64'(histos[0 +: CNTW]), 64'd15);
        repeat (2) begin
            coax_in[0] = 1'b1;
            repeat (2) tick();
            coax_in[0] = 1'b0;
            repeat (2) tick();
        end
        repeat (4) tick();
        check("ch0_hist_sat", 64'(histos[0 +: CNTW]), 64'd15);
        coax_in[0] = 1'b1;
        tick();
        coax_in[0] = 1'b0;
        tick();
        tick();
        resethist = 1'b1;
        tick();
        resethist = 1'b0;
        check("ch0_clear_fire_out", 64'(coax_out[0]), 64'd1);
        check("ch0_clear_wins", 64'(histos[0 +: CNTW]), 64'd0);
        repeat (4) tick();

        // Reset two cycles into an 8-cycle pulse with the input held high.
        firingticks = 8'd8;
        deadticks = 8'd5;
        coax_in[5] = 1'b1;
        tick();
        repeat (4) tick();
        check("ch5_pre_reset_out", 64'(coax_out[5]), 64'd1);
        do_reset(2);
        clr_stats();
        repeat (20) tick();
        check("ch5_post_reset_rises", 64'(rises[5]), 64'd1);
        check("ch5_post_reset_width", 64'(hi_cnt[5]), 64'd8);
        coax_in[5] = 1'b0;
        repeat (16) tick();

        // Randomized traffic against the model, with one reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            if (n % 40 == 0) begin
                firingticks = 8'($urandom_range(0, 5));
                deadticks = 8'($urandom_range(0, 6));
            end
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 3) == 0) coax_in[ch] = ~coax_in[ch];
            end
            resethist = ($urandom_range(0, 99) == 0);
            if (n == 750) do_reset(2);
            tick();
        end
        resethist = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/coax_pulse_shaper.md
COAX_PULSE_SHAPER -- requirements
Module: coax_pulse_shaper

Interface
REQ-001 Parameter NCH, default 16, number of coax channels.
REQ-002 Parameter NHIST, default 4, number of channels (0..NHIST-1) with fire counters; NHIST <= NCH.
REQ-003 Parameter CNTW, default 32, fire-counter width in bits.
REQ-004 Port clk_adc  input  1  sole clock; all logic on rising edge.
REQ-005 Port nrst  input  1  reset, asynchronous, active-low.
REQ-006 Port coax_in  input  NCH  raw asynchronous discriminator inputs.
REQ-007 Port firingticks  input  8  output pulse length in clk_adc cycles.
REQ-008 Port deadticks  input  8  dead time after pulse in clk_adc cycles.
REQ-009 Port resethist  input  1  synchronous clear of all counters.
REQ-010 Port coax_out  output  NCH  shaped, registered pulses, one bit per channel.
REQ-011 Port histos  output  NHIST x CNTW  per-channel accepted-fire counts.
REQ-012 Port busy  output  NCH  channel is in FIRE or DEAD.

Function
REQ-013 Each coax_in bit SHALL pass a 2-flop synchronizer, then a rising-edge detector (sync high, previous sync low).
REQ-014 Each channel SHALL run an independent FSM: IDLE, FIRE, DEAD.
REQ-015 IDLE + edge -> FIRE; latch firingticks and deadticks; load tick counter with max(firingticks,1).
REQ-016 In FIRE, coax_out high; counter decrements each cycle; at counter==1 go to DEAD if latched deadticks>0, else IDLE.
REQ-017 In DEAD, coax_out low; counter loaded with latched deadticks on entry, decrements; at counter==1 go to IDLE.
REQ-018 coax_out SHALL be high for exactly max(firingticks,1) cycles per accepted edge.
REQ-019 Latency: coax_out rises on the 3rd clk_adc edge after the first edge sampling coax_in high.
REQ-020 Edges arriving in FIRE or DEAD SHALL be ignored (not queued); an edge in the same cycle as DEAD->IDLE is ignored.
REQ-021 firingticks/deadticks changes mid-pulse SHALL NOT affect the pulse in progress.
REQ-022 busy SHALL be high exactly when the channel state is FIRE or DEAD.
REQ-023 histos[i] SHALL increment by 1 on each IDLE->FIRE transition of channel i.
REQ-024 histos SHALL saturate at 2^CNTW-1, never wrap.
REQ-025 resethist high SHALL clear all histos on the next edge; coincident with a fire, the clear wins and that fire is not counted.
REQ-026 resethist SHALL NOT affect FSMs, coax_out or busy.

Reset
REQ-027 nrst low SHALL asynchronously force all FSMs to IDLE, counters and latched ticks to 0, synchronizer and edge flops to 0, coax_out=0, busy=0, histos=0.
REQ-028 A coax_in bit high across reset release SHALL produce exactly one pulse (edge seen when synchronizer fills).
REQ-029 Reset asserted mid-pulse SHALL truncate the pulse immediately; no dead time is served after release.

Configuration
REQ-030 Macro COAX_VETO_COUNT_EN: when defined, add output veto_cnt (NHIST x 16), incrementing (saturating at 65535) on each edge ignored per REQ-020, cleared by resethist and nrst like histos.
REQ-031 Without COAX_VETO_COUNT_EN, the port veto_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 firingticks=4, deadticks=10, single 1-cycle-wide-or-longer pulse on coax_in[0] -> coax_out[0] high 4 cycles starting 3 edges after sampling, busy 14 cycles, histos[0]=1.
REQ-033 firingticks=0, deadticks=0, coax_in[1] toggled every 4 cycles x5 -> five 1-cycle coax_out[1] pulses, histos[1]=5.
REQ-034 firingticks=2, deadticks=20, edges on ch2 at t=0 and t=10 -> one pulse, histos[2]=1, veto_cnt[2]=1 when COAX_VETO_COUNT_EN.
REQ-035 Change firingticks 3->8 during FIRE on ch3 -> current pulse 3 cycles, next pulse 8 cycles.
REQ-036 Preload histos[0] to 2^CNTW-1 (CNTW=4 build, 15 fires) then 2 more fires -> stays 15; resethist coincident with a fire -> histos[0]=0.
REQ-037 nrst asserted 2 cycles into an 8-cycle pulse with coax_in held high -> coax_out 0 immediately; after release one new full pulse.
